split_2o: RTL
=============

Name: split_2o

Overview:
- Stream splitter, the inverse of the two-input channel merge used ahead of the linear 1x1 conv in the Inception-ResNet blocks.
- Input: one channel-concatenated feature-map stream.
- Output: the first CH_1 planes go to output 1 and the next CH_2 planes go to output 2, then the pattern repeats for the next image.
- Use: feeds two branch convolutions from one upstream layer whose channel groups go to different branches.

Parameters:
- IMG_SIZE, 17, plane width and height in pixels (a plane is IMG_SIZE*IMG_SIZE pixels, raster order).
- CH_1, 1, number of consecutive planes routed to output 1.
- CH_2, 1, number of consecutive planes routed to output 2.
- DATA_WIDTH, 32, pixel word width.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- valid_in  input  1  pxl_in is valid this cycle.
- pxl_in  input  DATA_WIDTH  input pixel.
- pxl_out_1  output  DATA_WIDTH  pixel for branch 1.
- valid_out_1  output  1  pxl_out_1 is valid.
- pxl_out_2  output  DATA_WIDTH  pixel for branch 2.
- valid_out_2  output  1  pxl_out_2 is valid.

Behaviour:
- Single clock domain: clk. reset is synchronous and active-high.
- Protocol: valid-only, no backpressure. Every valid_in beat is consumed. Gaps (valid_in=0) freeze all counters and state.
- Counters:
  - col: 0..IMG_SIZE-1.
  - row: 0..IMG_SIZE-1.
  - plane: 0..CH_1-1 in SEND_1, 0..CH_2-1 in SEND_2.
  - Counter widths are $clog2 of the range, minimum 1 bit.
- Counter advance, on each valid beat:
  - col increments.
  - At col=IMG_SIZE-1, col wraps to 0 and row increments.
  - At row=IMG_SIZE-1 with col=IMG_SIZE-1, row wraps and plane increments.
- FSM states: SEND_1, SEND_2.
  - SEND_1: a beat with plane=CH_1-1 and last pixel of the plane moves to SEND_2, with plane reset to 0.
  - SEND_2: a beat with plane=CH_2-1 and last pixel moves to SEND_1, with plane reset to 0. This is the image boundary.
  - No transition without a valid beat.
- Routing and latency: 1 cycle, all outputs registered.
  - Beat in SEND_1: next cycle valid_out_1=1, pxl_out_1=pxl_in, valid_out_2=0.
  - Beat in SEND_2: symmetric.
  - The two valid outputs are never high in the same cycle.
- Data hold:
  - pxl_out_1 and pxl_out_2 hold their last routed value while their valid is low.
  - The value on pxl_out_x is meaningful only when valid_out_x=1.
- Reset values: pxl_out_1=0, pxl_out_2=0, valid_out_1=0, valid_out_2=0, state=SEND_1, col=row=plane=0.
- Reset mid-image: the partial image is discarded. The first valid beat after reset deasserts is pixel 0 of plane 0 and routes to output 1.
- reset and valid_in in the same cycle: reset wins and the beat is dropped.
- Degenerate case: CH_1 and CH_2 must be ≥1 (elaboration-time check). IMG_SIZE=1 is legal, giving one-pixel planes.
- Arithmetic: no data arithmetic. pxl_in is passed bit-exact.

Optional Feature:
- Macro: SPLIT_2O_DONE_EN.
- Defined: adds output port done (1 bit, reset 0).
  - done pulses high for exactly one cycle, coincident with the valid_out_2 cycle that carries the last pixel of the last CH_2 plane (end of image).
- Undefined: no done port and no related logic. Routing behaviour is identical.

Decomposition:
- Shared package cnn_stream_pkg holds:
  - the state encoding enum (SEND_1, SEND_2);
  - a clog2-with-minimum-1 width function;
  - the pixel type sized by DATA_WIDTH (as a parameterized convention).
- One natural sub-module: raster_counter (params IMG_SIZE, N_PLANES).
  - Inputs: clk, reset, advance, clear.
  - Outputs: col, row, plane, plane_last, group_last.
  - Instantiated once. N_PLANES is the larger of CH_1 and CH_2, and the FSM supplies the active group limit.

Test Plan:
- Bench configuration: IMG_SIZE=3, CH_1=1, CH_2=2, DATA_WIDTH=32.
1. 27 back-to-back beats with pxl_in=0..26 -> pxl_out_1 shows 0..8 with valid_out_1 on 9 cycles, then pxl_out_2 shows 9..26 on 18 cycles; each output appears 1 cycle after its input; the valids never overlap.
2. Same 27 values with valid_in toggled 1,0,1,0 -> identical output sequence; outputs hold their value in gap cycles; counters do not advance.
3. 54 beats (two images, values 100..153) -> 100..108 to output 1, 109..126 to output 2, 127..135 to output 1, 136..153 to output 2.
4. Assert reset after 13 beats (mid plane 0 of output 2), then send 27 beats 200..226 -> all outputs are 0 during reset; 200..208 go to output 1, then 209..226 to output 2.
5. reset=1 together with valid_in=1, pxl_in=0xDEADBEEF -> no valid output next cycle; the following beat routes to output 1 as pixel 0.
6. With SPLIT_2O_DONE_EN, the scenario-1 stream -> done is high exactly one cycle, coincident with pxl_out_2=26; it stays 0 otherwise.

Source files
------------

// File: rtl/cnn_stream_pkg.sv
// Shared types and helpers for the CNN stream blocks.
// Holds the split FSM encoding, a minimum-1 clog2, and the default pixel type.
package cnn_stream_pkg;

  typedef enum logic {
    SEND_1 = 1'b0,
    SEND_2 = 1'b1
  } split_state_e;

  localparam int PIXEL_W = 32;

  typedef logic [PIXEL_W-1:0] pixel_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Column/row/plane raster counter for a channel-planar pixel stream.
// The plane counter wraps at an externally supplied group limit.
module raster_counter
  import cnn_stream_pkg::*;
#(
  parameter int IMG_SIZE = 17,
  parameter int N_PLANES = 1,
  localparam int CW = clog2_min1(IMG_SIZE),
  localparam int PW = clog2_min1(N_PLANES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          advance,
  input  logic          clear,
  input  logic [PW-1:0] group_max,
  output logic [CW-1:0] col,
  output logic [CW-1:0] row,
  output logic [PW-1:0] plane,
  output logic          plane_last,
  output logic          group_last
);

  localparam logic [CW-1:0] PIX_MAX = CW'(IMG_SIZE - 1);

  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic [PW-1:0] plane_q, plane_d;
  logic          col_last;

  always_comb begin
    col_last   = (col_q == PIX_MAX);
    plane_last = col_last && (row_q == PIX_MAX);
    group_last = plane_last && (plane_q == group_max);
  end

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    plane_d = plane_q;
    if (clear) begin
      col_d   = '0;
      row_d   = '0;
      plane_d = '0;
    end else if (advance) begin
      if (col_last) begin
        col_d = '0;
        if (row_q == PIX_MAX) begin
          row_d   = '0;
          plane_d = group_last ? '0 : plane_q + PW'(1);
        end else begin
          row_d = row_q + CW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q   <= '0;
      row_q   <= '0;
      plane_q <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      plane_q <= plane_d;
    end
  end

  assign col   = col_q;
  assign row   = row_q;
  assign plane = plane_q;

endmodule

// File: rtl/split_2o.sv
// Two-way channel-group stream splitter: CH_1 planes to out 1, CH_2 to out 2.
// Optional SPLIT_2O_DONE_EN adds a one-cycle end-of-image done pulse.
module split_2o
  import cnn_stream_pkg::*;
#(
  parameter int IMG_SIZE   = 17,
  parameter int CH_1       = 1,
  parameter int CH_2       = 1,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic [DATA_WIDTH-1:0] pxl_out_1,
  output logic                  valid_out_1,
  output logic [DATA_WIDTH-1:0] pxl_out_2,
  output logic                  valid_out_2
`ifdef SPLIT_2O_DONE_EN
  ,
  output logic                  done
`endif
);

  localparam int NP = (CH_1 > CH_2) ? CH_1 : CH_2;
  localparam int CW = clog2_min1(IMG_SIZE);
  localparam int PW = clog2_min1(NP);
  localparam logic [PW-1:0] G1_MAX = PW'(CH_1 - 1);
  localparam logic [PW-1:0] G2_MAX = PW'(CH_2 - 1);

  if (CH_1 < 1 || CH_2 < 1) begin : g_bad_ch
    $error("split_2o: CH_1 and CH_2 must be >= 1");
  end

  split_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] pxl_1_q, pxl_1_d;
  logic [DATA_WIDTH-1:0] pxl_2_q, pxl_2_d;
  logic                  vld_1_q, vld_1_d;
  logic                  vld_2_q, vld_2_d;
  logic [PW-1:0]         group_max;
  logic [CW-1:0]         col;
  logic [CW-1:0]         row;
  logic [PW-1:0]         plane;
  logic                  plane_last;
  logic                  group_last;

  assign group_max = (state_q == SEND_1) ? G1_MAX : G2_MAX;

  raster_counter #(
    .IMG_SIZE (IMG_SIZE),
    .N_PLANES (NP)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .advance    (valid_in),
    .clear      (1'b0),
    .group_max  (group_max),
    .col        (col),
    .row        (row),
    .plane      (plane),
    .plane_last (plane_last),
    .group_last (group_last)
  );

  always_comb begin
    state_d = state_q;
    pxl_1_d = pxl_1_q;
    pxl_2_d = pxl_2_q;
    vld_1_d = 1'b0;
    vld_2_d = 1'b0;
    unique case (state_q)
      SEND_1: begin
        if (valid_in) begin
          vld_1_d = 1'b1;
          pxl_1_d = pxl_in;
          if (group_last) state_d = SEND_2;
        end
      end
      SEND_2: begin
        if (valid_in) begin
          vld_2_d = 1'b1;
          pxl_2_d = pxl_in;
          if (group_last) state_d = SEND_1;
        end
      end
      default: state_d = SEND_1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEND_1;
      pxl_1_q <= '0;
      pxl_2_q <= '0;
      vld_1_q <= 1'b0;
      vld_2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pxl_1_q <= pxl_1_d;
      pxl_2_q <= pxl_2_d;
      vld_1_q <= vld_1_d;
      vld_2_q <= vld_2_d;
    end
  end

  assign pxl_out_1   = pxl_1_q;
  assign pxl_out_2   = pxl_2_q;
  assign valid_out_1 = vld_1_q;
  assign valid_out_2 = vld_2_q;

`ifdef SPLIT_2O_DONE_EN
  logic done_q, done_d;

  assign done_d = valid_in && (state_q == SEND_2) && group_last;

  always_ff @(posedge clk) begin
    if (reset) done_q <= 1'b0;
    else       done_q <= done_d;
  end

  assign done = done_q;
`endif

  logic unused_ok;
  assign unused_ok = ^{col, row, plane, plane_last};

endmodule
